// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, even parity, one-entry hold register.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx #(
    parameter int DATABITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                baud16,
    input  logic                tx_start,
    input  logic [DATABITS-1:0] tx_data,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_line,
    output logic                tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [2:0] STOP2  = 3'd5;
`endif
    localparam logic [3:0] LAST_BIT = 4'(DATABITS - 1);

    logic [2:0]          state, state_n;
    logic [3:0]          tick_cnt, tick_n;
    logic [3:0]          bit_cnt, bit_n;
    logic [DATABITS-1:0] shift_reg, shift_n;
    logic [DATABITS-1:0] hold_reg;
    logic                parity_reg, parity_n;
    logic                hold_valid, hold_valid_n;
    logic                accept, bit_end, last_end, load, line_n;

    assign tx_ready = !hold_valid;
    assign accept   = tx_start && !hold_valid;
    assign bit_end  = baud16 && (tick_cnt == 4'd15);

`ifdef UART_TX_TWO_STOP_EN
    assign last_end = (state == STOP2) && bit_end;
`else
    assign last_end = (state == STOP) && bit_end;
`endif

    // Reload from hold either when idle or right as the final stop bit ends.
    assign load = hold_valid && ((state == IDLE) || last_end);

    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift_reg;
        parity_n = parity_reg;
        if ((state != IDLE) && baud16) begin
            tick_n = tick_cnt + 4'd1;
        end
        case (state)
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift_reg >> 1;
                    bit_n   = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) state_n = PARITY;
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                if (bit_end) state_n = STOP2;
            end
            STOP2: begin
                if (bit_end) state_n = IDLE;
            end
`else
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n  = START;
            tick_n   = 4'd0;
            bit_n    = 4'd0;
            shift_n  = hold_reg;
            parity_n = ^hold_reg;
        end
        hold_valid_n = accept ? 1'b1 : (load ? 1'b0 : hold_valid);
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift_n[0];
            PARITY:  line_n = parity_n;
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= 4'd0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            parity_reg <= 1'b0;
            hold_valid <= 1'b0;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            parity_reg <= parity_n;
            hold_valid <= hold_valid_n;
            if (accept) hold_reg <= tx_data;
            tx_line    <= line_n;
            tx_busy    <= (state_n != IDLE) || hold_valid_n;
            tx_done    <= last_end;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a line-decoding monitor and byte scoreboard.
// Build with UART_TX_TWO_STOP_EN defined to cover the two-stop-bit frame.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif
    localparam int FRAME = NB * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud16 = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_line, tx_done;

    uart_tx #(.DATABITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .baud16(baud16),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .tx_line(tx_line),
        .tx_done(tx_done)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]    sb[$];
    bit            in_frame = 0;
    bit            done_pend = 0;
    int            mon_p = 0;
    int            gap = 1000;
    int            last_gap = 1000;
    int            frames = 0;
    int            done_cnt = 0;
    logic [NB-1:0] cur = '1;

    initial forever #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 baud16 = 1'b1;
            @(posedge clk);
            #1 baud16 = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ^b;
        return f;
    endfunction

    // Monitor: a baud16 pulse seen at a negedge is consumed at the next posedge.
    always @(negedge clk) begin
        bit exp_done;
        exp_done  = done_pend;
        done_pend = 0;
        if (!reset) begin
            in_frame = 0;
            mon_p    = 0;
        end else begin
            check("done_pulse", tx_done, exp_done);
            if (tx_done) done_cnt++;
            if (!in_frame) begin
                gap++;
                if (tx_line === 1'b0) begin
                    in_frame = 1;
                    mon_p    = 0;
                    last_gap = gap;
                    frames++;
                    check("frame_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) cur = frame_of(sb.pop_front());
                    else cur = '1;
                end
            end
            if (in_frame) begin
                check("line_bit", tx_line, cur[mon_p / 16]);
                if (baud16) mon_p++;
                if (mon_p == FRAME) begin
                    in_frame  = 0;
                    done_pend = 1;
                    gap       = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", tx_ready, 1);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
        if (push) sb.push_back(d);
        #1 tx_start = 1'b0;
        check("accept_ready", tx_ready, 0);
        check("accept_busy", tx_busy, 1);
        if (lat) begin
            check("lat1_line", tx_line, 1);
            @(posedge clk);
            #1;
            check("lat2_line", tx_line, 0);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, done_cnt >= target, 1);
    endtask

    initial begin
        int base;
        int fr;
        int n;

        tx_start = 1'b1;
        tx_data  = 8'h5A;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_line", tx_line, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_ready", tx_ready, 1);
            check("rst_done", tx_done, 0);
        end
        @(negedge clk);
        tx_start = 1'b0;
        reset    = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("post_rst_line", tx_line, 1);
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_frames", frames, 0);

        base = done_cnt;
        send(8'hA5, 1, 1);
        wait_done(base + 1, "a5_done");
        check("a5_busy_fall", tx_busy, 0);
        check("a5_ready", tx_ready, 1);
        repeat (50) @(negedge clk);
        #1;
        check("a5_one_done", done_cnt, base + 1);

        base = done_cnt;
        send(8'h07, 1, 0);
        wait_done(base + 1, "p07_done");

        base = done_cnt;
        fr   = frames;
        send(8'h3C, 1, 0);
        send(8'hC3, 1, 0);
        @(negedge clk);
        check("b2b_full", tx_ready, 0);
        tx_start = 1'b1;
        tx_data  = 8'h99;
        @(posedge clk);
        #1 tx_start = 1'b0;
        wait_done(base + 1, "b2b_done1");
        repeat (2) @(negedge clk);
        #1;
        check("b2b_gap", last_gap, 1);
        wait_done(base + 2, "b2b_done2");
        repeat (800) @(negedge clk);
        #1;
        check("b2b_done_cnt", done_cnt, base + 2);
        check("b2b_frames", frames, fr + 2);
        check("b2b_sb_empty", sb.size(), 0);
        check("b2b_idle_busy", tx_busy, 0);

        base = done_cnt;
        fr   = frames;
        send(8'hFF, 1, 0);
        send(8'h81, 0, 0);
        n = 0;
        while (!(in_frame && mon_p >= 72) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_reached", in_frame && mon_p >= 72, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_line", tx_line, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", tx_done, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        #1;
        check("mid_idle_line", tx_line, 1);
        check("mid_idle_busy", tx_busy, 0);
        check("mid_no_done", done_cnt, base);
        check("mid_frames", frames, fr + 1);

        base = done_cnt;
        fr   = frames;
        send(8'h00, 1, 0);
        send(8'h55, 1, 0);
        send(8'hFF, 1, 0);
        wait_done(base + 1, "lb_done1");
        wait_done(base + 2, "lb_done2");
        wait_done(base + 3, "lb_done3");
        repeat (20) @(negedge clk);
        #1;
        check("lb_frames", frames, fr + 3);
        check("lb_sb_empty", sb.size(), 0);
        check("lb_busy", tx_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART link; the matching sender for the project's uart_rx.
- Frame format: start bit (0), DATABITS data bits LSB first, one even-parity bit, one stop bit (1). The even-parity bit is the XOR of the data bits.
- Each bit lasts 16 baud16 ticks, driven from the shared 16x baud enable.
- A one-entry holding register accepts the next byte while the current frame shifts, so frames can go back-to-back with no idle gap.

Parameters:
- DATABITS, 8, number of data bits per frame (1-15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- baud16  input  1  one-clk-wide enable pulse at 16x baud rate.
- tx_start  input  1  request to send tx_data; accepted only when tx_ready=1.
- tx_data  input  DATABITS  byte to send; sampled on the accepting edge.
- tx_ready  output  1  holding register empty; equals !hold_valid (combinational).
- tx_busy  output  1  registered; 1 while state!=IDLE or hold_valid=1.
- tx_line  output  1  registered serial output; idles high.
- tx_done  output  1  one-clk pulse when the final stop bit completes.

Behaviour:
- Reset (async assert, reset=0):
  - tx_line=1, tx_busy=0, tx_done=0, hold_valid=0 (so tx_ready=1).
  - state=IDLE; counters and registers cleared.
  - Mid-frame assertion aborts the frame immediately and discards held data; no tx_done.
  - Deassertion is used synchronously.
- Accept: at an edge where tx_start=1 and tx_ready=1, hold_reg<=tx_data and hold_valid<=1. When tx_ready=0, tx_start is ignored; held data is never overwritten.
- State machine: IDLE, START, DATA, PARITY, STOP, with STOP2 only when the optional feature is compiled in.
- IDLE:
  - tx_line=1.
  - If hold_valid=1: shift_reg<=hold_reg, parity_reg<=^hold_reg, hold_valid<=0, tick_cnt<=0, bit_cnt<=0, state<=START.
  - This load does not wait for baud16. tx_line goes low on the edge after the accept edge (2-cycle latency from the tx_start edge).
- Tick counting (all non-IDLE states): tick_cnt (4 bits) increments only on cycles with baud16=1. On baud16=1 with tick_cnt==15, tick_cnt<=0 and the bit ends. Every bit is exactly 16 baud16 pulses.
- START: tx_line=0. At bit end go to DATA.
- DATA:
  - tx_line=shift_reg[0].
  - At bit end: shift right by one, bit_cnt+1.
  - When bit_cnt==DATABITS-1, go to PARITY instead.
- PARITY: tx_line=parity_reg. At bit end go to STOP.
- STOP:
  - tx_line=1.
  - At bit end: tx_done<=1 for one clk.
  - If hold_valid=1 (or being set this edge is not visible; use the registered value), reload from hold exactly as in IDLE and go straight to START: back-to-back, no idle cycles.
  - Otherwise go to IDLE.
- Simultaneous events:
  - tx_start accepted on the same edge hold_reg is transferred out (IDLE or STOP reload): the transfer takes the old hold_reg, the new data is written, and hold_valid stays 1.
  - tx_start while hold_valid=1 and no transfer that edge: ignored.
- Frame length: (DATABITS+3)*16 baud16 pulses; 176 for DATABITS=8.
- tx_busy falls on the edge that enters IDLE with hold_valid=0.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: after STOP, the FSM enters STOP2 (tx_line=1, 16 ticks). tx_done and the reload/IDLE decision move to the end of STOP2. Frame length becomes (DATABITS+4)*16 pulses; 192 for DATABITS=8. The frame stays compatible with uart_rx.
- Undefined: single stop bit; the STOP2 state and its logic are absent.

Test Plan:
- Reset: hold reset=0 for 3 clks with tx_start=1 -> tx_line=1, tx_busy=0, tx_ready=1, tx_done=0 throughout. No frame after release until a fresh tx_start.
- Single frame, tx_data=0xA5, baud16 every 4 clks -> tx_line goes low 2 clks after accept, then sends 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit is 16 baud16 pulses (176 total). Exactly one tx_done pulse; tx_busy falls afterwards.
- Parity odd-count: tx_data=0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1.
- Back-to-back: send 0x3C, then 0xC3 mid-frame (tx_ready falls) -> 0xC3's start bit follows 0x3C's stop bit with zero extra clks. Two tx_done pulses 176 pulses apart. A third tx_start while tx_ready=0 is ignored (only two frames on the line).
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF with a byte held -> tx_line=1 asynchronously, no tx_done. Held byte discarded; the line stays idle after release.
- Loopback into uart_rx with DATABITS=8, bytes 0x00, 0x55, 0xFF -> rx_done once per byte, rx_data matches, parity_error=0. Repeat with UART_TX_TWO_STOP_EN defined (192-pulse frames, same results).
